// File: rtl/eth_pkt_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eth_pkt_loader - writes the received byte stream into two ping-pong RAM slots
//                  and offers completed packets to ecpri_rx in arrival order.
// Rev 1.0
// ----------------------------------------------------------------------------
module eth_pkt_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SLOT_SIZE  = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  recv_pkt,
  output logic [ADDR_WIDTH-1:0] pkt_base,
  output logic [ADDR_WIDTH-1:0] pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           drop_cnt
);

  localparam int c_off_w = $clog2(SLOT_SIZE) + 1;
  localparam logic [c_off_w-1:0]    c_slot_off   = c_off_w'(SLOT_SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_slot1_base = ADDR_WIDTH'(SLOT_SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_wr_slot;
  logic                  r_rd_slot;
  logic [1:0]            r_slot_full;
  logic [c_off_w-1:0]    r_offset;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_len [2];
  logic                  r_cmpl_pend;
  logic                  r_cmpl_slot;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic                  r_recv;
  logic [ADDR_WIDTH-1:0] r_pkt_base;
  logic [ADDR_WIDTH-1:0] r_pkt_len;
  logic [15:0]           r_drop_cnt;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_off_full;
  logic [ADDR_WIDTH-1:0] w_wr_base;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_base;
  logic [ADDR_WIDTH-1:0] w_len_next;
  logic [15:0]           w_drop_next;

  // Gated by reset so the source sees no ready while the block is held in reset.
  assign w_in_ready  = reset && ((r_state != S_IDLE) || !r_slot_full[r_wr_slot]);
  assign w_accept    = in_valid && w_in_ready;
  assign w_off_full  = (r_offset == c_slot_off);
  assign w_wr_base   = r_wr_slot ? c_slot1_base : '0;
  assign w_wr_addr   = w_wr_base + ADDR_WIDTH'(r_offset);
  assign w_rd_base   = r_rd_slot ? c_slot1_base : '0;
  assign w_len_next  = ADDR_WIDTH'(r_offset + c_off_w'(1));
  assign w_drop_next = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : r_drop_cnt + 16'd1;

  assign in_ready  = w_in_ready;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_cs    = r_ram_cs;
  assign ram_we    = r_ram_we;
  assign ram_oe    = 1'b0;
  assign recv_pkt  = r_recv;
  assign pkt_base  = r_pkt_base;
  assign pkt_len   = r_pkt_len;
  assign drop_cnt  = r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_slot   <= 1'b0;
      r_rd_slot   <= 1'b0;
      r_slot_full <= 2'b00;
      r_offset    <= '0;
      r_busy      <= 1'b0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_cmpl_pend <= 1'b0;
      r_cmpl_slot <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_recv      <= 1'b0;
      r_pkt_base  <= '0;
      r_pkt_len   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_recv      <= 1'b0;
      r_cmpl_pend <= 1'b0;

      // Slot is marked full one edge after its last byte, once that byte is in RAM.
      if (r_cmpl_pend) begin
        r_slot_full[r_cmpl_slot] <= 1'b1;
      end

      if (r_busy) begin
        if (pkt_done) begin
          r_slot_full[r_rd_slot] <= 1'b0;
          r_rd_slot              <= ~r_rd_slot;
          r_busy                 <= 1'b0;
        end
      end else if (r_slot_full[r_rd_slot]) begin
        r_recv     <= 1'b1;
        r_busy     <= 1'b1;
        r_pkt_base <= w_rd_base;
        r_pkt_len  <= r_len[r_rd_slot];
      end

      case (r_state)
        S_IDLE, S_WRITE: begin
          if (w_accept) begin
            if (w_off_full) begin
              if (in_last) begin
                r_drop_cnt <= w_drop_next;
                r_offset   <= '0;
                r_state    <= S_IDLE;
              end else begin
                r_state <= S_DROP;
              end
            end else begin
              r_ram_cs    <= 1'b1;
              r_ram_we    <= 1'b1;
              r_ram_addr  <= w_wr_addr;
              r_ram_wdata <= in_data;
              if (in_last) begin
                r_len[r_wr_slot] <= w_len_next;
                r_cmpl_pend      <= 1'b1;
                r_cmpl_slot      <= r_wr_slot;
                r_wr_slot        <= ~r_wr_slot;
                r_offset         <= '0;
                r_state          <= S_IDLE;
              end else begin
                r_offset <= r_offset + c_off_w'(1);
                r_state  <= S_WRITE;
              end
            end
          end
        end
        S_DROP: begin
          if (w_accept && in_last) begin
            r_drop_cnt <= w_drop_next;
            r_offset   <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_pkt_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_eth_pkt_loader - directed bench with a packet-level slot/queue model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_eth_pkt_loader;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int SS = 2048;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_last  = 1'b0;
  logic          pkt_done = 1'b0;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic          recv_pkt;
  logic [AW-1:0] pkt_base;
  logic [AW-1:0] pkt_len;
  logic [15:0]   drop_cnt;

  eth_pkt_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_SIZE(SS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .recv_pkt(recv_pkt), .pkt_base(pkt_base), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packet-level model: expected RAM writes and offers in arrival order.
  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [15:0] base; logic [15:0] len; } off_t;
  wr_t  exp_wr_q[$];
  off_t exp_off_q[$];
  int   m_wr_slot = 0;

  int          wr_seen      = 0;
  int          recv_seen    = 0;
  int          recv_cyc     = 0;
  int          last_acc_cyc = 0;
  int          done_cyc     = 0;
  logic [15:0] last_wr_addr = '0;
  logic        cmp_busy     = 1'b0;
  logic [15:0] cmp_base     = '0;
  logic [15:0] cmp_len      = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t  e;
    off_t o;
    if (!reset) begin
      cmp_busy = 1'b0;
    end else begin
      chk("ram_oe", ram_oe, 0);
      chk("ram_we_eq_cs", ram_we, ram_cs);
      if (ram_cs) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write", ram_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_wdata, e.d);
        end
        wr_seen++;
        last_wr_addr = ram_addr;
      end
      if (recv_pkt) begin
        chk("recv_while_busy", cmp_busy, 0);
        if (exp_off_q.size() == 0) begin
          chk("unexpected_recv", pkt_base, 32'hFFFF_FFFF);
        end else begin
          o = exp_off_q.pop_front();
          chk("offer_base", pkt_base, o.base);
          chk("offer_len", pkt_len, o.len);
        end
        cmp_busy  = 1'b1;
        cmp_base  = pkt_base;
        cmp_len   = pkt_len;
        recv_seen++;
        recv_cyc  = cyc;
      end else if (cmp_busy) begin
        chk("base_stable", pkt_base, cmp_base);
        chk("len_stable", pkt_len, cmp_len);
        if (pkt_done) cmp_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input int idx,
                           input int len, input logic done_on_last, output int stalls);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (last && done_on_last) pkt_done = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: byte %0d not accepted after %0d cycles", idx, n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        pkt_done = 1'b0;
        stalls   = n;
        return;
      end
      @(negedge clk);
    end
    if (idx < SS) exp_wr_q.push_back('{a: 16'(m_wr_slot * SS + idx), d: d});
    if (last && len <= SS) begin
      exp_off_q.push_back('{base: 16'(m_wr_slot * SS), len: 16'(len)});
      m_wr_slot ^= 1;
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    if (pkt_done) done_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    pkt_done = 1'b0;
    stalls   = n;
  endtask

  task automatic send_pkt(input int len, input int start, input logic done_on_last,
                          output int first_stall);
    int st;
    first_stall = 0;
    for (int i = 0; i < len; i++) begin
      send_byte(8'(start + i), (i == len - 1), i, len, done_on_last, st);
      if (i == 0) first_stall = st;
    end
  endtask

  task automatic wait_recv(input int n, input string name);
    int k;
    k = 0;
    while (recv_seen < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (recv_seen < n) begin
      errors++;
      $display("FAIL %s: recv_pkt count %0d, required %0d", name, recv_seen, n);
    end
  endtask

  task automatic pulse_done();
    pkt_done = 1'b1;
    @(posedge clk);
    #1;
    done_cyc = cyc;
    pkt_done = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_wr_q.delete();
    exp_off_q.delete();
    m_wr_slot = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_ram_cs"}, ram_cs, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_oe"}, ram_oe, 0);
    chk({tag, "_recv_pkt"}, recv_pkt, 0);
    chk({tag, "_pkt_base"}, pkt_base, 0);
    chk({tag, "_pkt_len"}, pkt_len, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int st;
    int w0;
    int r0;
    int dm;

    // Reset state
    @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // 60-byte packet into slot 0
    w0 = wr_seen;
    send_pkt(60, 8'h00, 1'b0, st);
    wait_recv(1, "t1_recv");
    chk("t1_latency", recv_cyc - last_acc_cyc, 2);
    chk("t1_base", pkt_base, 16'h0000);
    chk("t1_len", pkt_len, 60);
    chk("t1_writes", wr_seen - w0, 60);
    pulse_done();

    // Three 64-byte packets with both slots filling up
    do_reset();
    r0 = recv_seen;
    send_pkt(64, 8'h40, 1'b0, st);
    send_pkt(64, 8'h80, 1'b0, st);
    chk("t2_no_bubble", st, 0);
    wait_recv(r0 + 1, "t2_p1_recv");
    chk("t2_p1_base", pkt_base, 16'h0000);
    @(negedge clk);
    chk("t2_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    pulse_done();
    dm = done_cyc;
    @(negedge clk);
    chk("t2_ready_rise", in_ready, 1);
    wait_recv(r0 + 2, "t2_p2_recv");
    chk("t2_p2_cycle", recv_cyc - dm, 1);
    chk("t2_p2_base", pkt_base, 16'h0800);
    chk("t2_p2_len", pkt_len, 64);
    send_pkt(64, 8'hC0, 1'b0, st);
    settle();
    chk("t2_p3_last_addr", last_wr_addr, 16'h003F);
    pulse_done();
    wait_recv(r0 + 3, "t2_p3_recv");
    chk("t2_p3_base", pkt_base, 16'h0000);
    pulse_done();

    // Oversize packets, then a short one reusing slot 0
    do_reset();
    w0 = wr_seen;
    r0 = recv_seen;
    send_pkt(2049, 8'h00, 1'b0, st);
    settle();
    chk("t3_writes", wr_seen - w0, 2048);
    chk("t3_drop1", drop_cnt, 1);
    send_pkt(2060, 8'h11, 1'b0, st);
    settle();
    chk("t3_drop2", drop_cnt, 2);
    chk("t3_writes2", wr_seen - w0, 4096);
    chk("t3_no_recv", recv_seen, r0);
    send_pkt(10, 8'hA0, 1'b0, st);
    wait_recv(r0 + 1, "t3_short_recv");
    chk("t3_short_base", pkt_base, 16'h0000);
    chk("t3_short_len", pkt_len, 10);
    pulse_done();

    // Single-byte packet lands in slot 1
    send_pkt(1, 8'h5A, 1'b0, st);
    wait_recv(r0 + 2, "t4_recv");
    chk("t4_base", pkt_base, 16'h0800);
    chk("t4_len", pkt_len, 1);
    pulse_done();

    // pkt_done for slot 0 on the edge slot 1's last byte is accepted
    do_reset();
    r0 = recv_seen;
    send_pkt(8, 8'h20, 1'b0, st);
    wait_recv(r0 + 1, "t5_a_recv");
    send_pkt(8, 8'h30, 1'b1, st);
    dm = done_cyc;
    @(negedge clk);
    chk("t5_ready", in_ready, 1);
    wait_recv(r0 + 2, "t5_b_recv");
    chk("t5_cycle", recv_cyc - dm, 2);
    chk("t5_base", pkt_base, 16'h0800);
    chk("t5_len", pkt_len, 8);
    pulse_done();

    // Reset with an offer pending and a partial packet in flight
    send_pkt(5, 8'h60, 1'b0, st);
    wait_recv(r0 + 3, "t6_c_recv");
    chk("t6_c_len", pkt_len, 5);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h70 + i), 1'b0, i, 20, 1'b0, st);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_wr_q.delete();
    exp_off_q.delete();
    m_wr_slot = 0;
    r0 = recv_seen;
    send_pkt(12, 8'h90, 1'b0, st);
    wait_recv(r0 + 1, "t6_recv");
    chk("t6_base", pkt_base, 16'h0000);
    chk("t6_len", pkt_len, 12);
    pulse_done();
    settle();

    chk("end_wr_queue_empty", exp_wr_q.size(), 0);
    chk("end_offer_queue_empty", exp_off_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_pkt_loader.md
# eth_pkt_loader

Ingress sequencer for the received-Ethernet-packet RAM (`ram_dp_sr_sw`, port 0). It accepts a byte stream from the MAC-side FIFO and writes each packet into one of two ping-pong slots in the RAM. It then hands completed packets one at a time to `ecpri_rx` with a `recv_pkt` pulse plus base and length, and frees a slot when `ecpri_rx` reports completion. Oversize packets are discarded and counted.

## Interface
- DATA_WIDTH, 8, byte width of stream and RAM data
- ADDR_WIDTH, 16, RAM address width
- SLOT_SIZE, 2048, bytes per slot; power of two; 2*SLOT_SIZE <= 2^ADDR_WIDTH

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid  in  1  stream byte valid
- in_data  in  DATA_WIDTH  stream byte
- in_last  in  1  byte is the last of its packet
- in_ready  out  1  byte accepted on the edge where in_valid && in_ready
- ram_addr  out  ADDR_WIDTH  RAM port-0 address
- ram_wdata  out  DATA_WIDTH  RAM port-0 write data (top level drives the bidir data_0 from this)
- ram_cs  out  1  chip select, high only on write cycles
- ram_we  out  1  write enable, high only on write cycles
- ram_oe  out  1  held 0; port 0 is write-only
- recv_pkt  out  1  one-cycle pulse: a packet is ready for `ecpri_rx`
- pkt_base  out  ADDR_WIDTH  slot base of the offered packet; stable from recv_pkt until pkt_done
- pkt_len  out  ADDR_WIDTH  byte count of the offered packet; stable with pkt_base
- pkt_done  in  1  one-cycle pulse from `ecpri_rx`: offered packet consumed
- drop_cnt  out  16  count of oversize packets dropped; saturates at 0xFFFF

## Operation
- Slot s occupies addresses s*SLOT_SIZE .. s*SLOT_SIZE+SLOT_SIZE-1, with s in {0,1}.
- State: wr_slot, rd_slot, slot_full[1:0], offset (log2(SLOT_SIZE)+1 bits), busy.
- Write FSM states:
  - IDLE: in_ready = !slot_full[wr_slot]. The first accepted byte goes to WRITE; if it also carries in_last, the packet completes immediately.
  - WRITE: in_ready=1. Each accepted byte is written at wr_slot*SLOT_SIZE+offset, and offset increments.
    - An accepted in_last with total length <= SLOT_SIZE sets slot_full[wr_slot], latches the length into that slot's length register, toggles wr_slot, clears offset, and returns to IDLE.
    - A byte accepted with offset == SLOT_SIZE and not last goes to DROP. The byte is not written.
  - DROP: in_ready=1. Bytes are discarded up to and including in_last. Then drop_cnt++, offset=0, wr_slot is unchanged, and the FSM returns to IDLE. Bytes already written to the slot are left stale.
- Notify FSM:
  - If !busy && slot_full[rd_slot]: pulse recv_pkt, drive pkt_base = rd_slot*SLOT_SIZE and pkt_len, and set busy.
  - On pkt_done while busy: clear slot_full[rd_slot], toggle rd_slot, clear busy.
  - pkt_done while !busy is ignored.
- Packet order to `ecpri_rx` equals arrival order. Zero-length packets cannot occur.
- A slot completing and pkt_done freeing the other slot on the same edge both take effect.
- Reset mid-packet abandons the partial packet. Both slots become empty, and a pending offer is withdrawn.

## Timing
- Reset values: in_ready=0 while reset is low (1 after release, since both slots are empty). All other outputs 0, including ram_oe=0 and drop_cnt=0.
- RAM outputs are registered. A byte accepted at edge N drives ram_addr/ram_wdata/ram_cs/ram_we during cycle N..N+1, and the RAM captures it at edge N+1.
- Last byte accepted at edge N: slot_full is set at edge N+1 and recv_pkt is high for cycle N+2..N+3. The packet is fully in RAM before the notification.
- pkt_done sampled at edge M: busy clears at M. If the other slot is full, the next recv_pkt is registered at M+1.
- With both slots full, in_ready stays low in IDLE. It rises the cycle after the pkt_done edge that frees wr_slot.
- Throughput: one byte per cycle sustained, with no bubble between packets while a slot is free.

## Test plan
- 60-byte packet, bytes 0x00..0x3B, in_valid held high: 60 writes to addresses 0x0000..0x003B with matching data. One recv_pkt 2 cycles after the last byte, with pkt_base=0x0000 and pkt_len=60.
- Three back-to-back 64-byte packets, pkt_done held low:
  - packets 1 and 2 land at 0x0000 and 0x0800;
  - in_ready is 0 before packet 3;
  - pkt_done frees slot 0, packet 3 is written at 0x0000, and recv_pkt for slot 1 (pkt_base=0x0800) fires the cycle after pkt_done.
- 2049-byte packet: exactly 2048 writes (0x0000..0x07FF), no recv_pkt, drop_cnt=1. A following 10-byte packet is written at 0x0000 with pkt_len=10.
- 1-byte packet (in_last on the first byte): one write, recv_pkt with pkt_len=1.
- pkt_done for slot 0 on the same edge that the last byte of slot 1's packet is accepted: slot 0 is freed, slot 1 is marked full, and the next recv_pkt carries pkt_base=0x0800.
- reset low for 2 cycles after 10 bytes of a packet:
  - all outputs return to 0 and drop_cnt is unchanged at 0;
  - the next packet is written from 0x0000;
  - recv_pkt shows its length only.
